// File: rtl/jogo_memoria_pkg.sv
// rtl/jogo_memoria_pkg.sv - shared state encoding and RAM reset pattern for the memory game
package jogo_memoria_pkg;

    typedef enum logic [4:0] {
        INICIAL        = 5'd0,
        PREPARA        = 5'd1,
        MOSTRA         = 5'd2,
        ESPERA         = 5'd3,
        REGISTRA       = 5'd4,
        COMPARA        = 5'd5,
        ESPERA_NOVA    = 5'd6,
        GRAVA_NOVA     = 5'd7,
        PROXIMA_RODADA = 5'd8,
        FIM_GANHOU     = 5'd10,
        FIM_PERDEU     = 5'd14,
        FIM_TIMEOUT    = 5'd15
    } estado_t;

    // Power-on sequence walks the buttons in order: 0001, 0010, 0100, ...
    function automatic int padrao_inicial(input int k, input int botoes);
        return 1 << (k % botoes);
    endfunction

endpackage

// File: rtl/jogo_memoria_if.sv
// rtl/jogo_memoria_if.sv - board-side signal bundle of the memory game core
interface jogo_memoria_if #(
    parameter int BOTOES      = 4,
    parameter int MAX_RODADAS = 16
);
    localparam int AW = $clog2(MAX_RODADAS);

    logic              iniciar;
    logic              modo;
    logic [BOTOES-1:0] botoes;
    logic [BOTOES-1:0] leds;
    logic              pronto;
    logic              ganhou;
    logic              perdeu;
    logic              db_timeout;
    logic [4:0]        db_estado;
    logic [AW-1:0]     db_rodada;
    logic [AW-1:0]     db_contagem;
    logic [BOTOES-1:0] db_jogada;

    modport master (
        output iniciar, modo, botoes,
        input  leds, pronto, ganhou, perdeu, db_timeout,
        input  db_estado, db_rodada, db_contagem, db_jogada
    );

    modport slave (
        input  iniciar, modo, botoes,
        output leds, pronto, ganhou, perdeu, db_timeout,
        output db_estado, db_rodada, db_contagem, db_jogada
    );
endinterface

// File: rtl/jogo_memoria_ram.sv
// rtl/jogo_memoria_ram.sv - move sequence register file, async reset init, comb read, sync write
module jogo_memoria_ram
    import jogo_memoria_pkg::*;
#(
    parameter int BOTOES      = 4,
    parameter int MAX_RODADAS = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           we,
    input  logic [$clog2(MAX_RODADAS)-1:0] waddr,
    input  logic [BOTOES-1:0]              wdata,
    input  logic [$clog2(MAX_RODADAS)-1:0] raddr,
    output logic [BOTOES-1:0]              rdata
);

    logic [BOTOES-1:0] mem [MAX_RODADAS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MAX_RODADAS; k++) begin
                mem[k] <= BOTOES'(padrao_inicial(k, BOTOES));
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jogo_memoria_param.sv
// rtl/jogo_memoria_param.sv - parametrised memory game core: FSM, timer, counters, press detector
module jogo_memoria_param
    import jogo_memoria_pkg::*;
#(
    parameter int BOTOES         = 4,
    parameter int MAX_RODADAS    = 16,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int MOSTRA_CICLOS  = 2000
) (
    input logic          clock,
    input logic          reset,
    jogo_memoria_if.slave bus
);

    localparam int AW   = $clog2(MAX_RODADAS);
    localparam int TMAX = (TIMEOUT_CICLOS > MOSTRA_CICLOS) ? TIMEOUT_CICLOS : MOSTRA_CICLOS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [AW-1:0] UM = 1;

    estado_t           estado, proximo;
    logic [AW-1:0]     rodada, contagem, rodada_prox;
    logic [TW-1:0]     timer;
    logic [BOTOES-1:0] jogada, botoes_ant, ram_rdata;
    logic              modo_r, pressionou, expirou, acerto, conta;

    // A press is only the 0 -> non-zero transition, so a held button counts once.
    assign pressionou  = (bus.botoes != '0) && (botoes_ant == '0);
    assign expirou     = (timer == TW'(TIMEOUT_CICLOS - 1));
    assign acerto      = $onehot(jogada) && (jogada == ram_rdata);
    assign conta       = (estado == MOSTRA) || (estado == ESPERA) || (estado == ESPERA_NOVA);
    assign rodada_prox = rodada + UM;

    jogo_memoria_ram #(
        .BOTOES      (BOTOES),
        .MAX_RODADAS (MAX_RODADAS)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (estado == GRAVA_NOVA),
        .waddr (rodada_prox),
        .wdata (bus.botoes),
        .raddr (contagem),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo        = estado;
        bus.leds       = '0;
        bus.pronto     = 1'b0;
        bus.ganhou     = 1'b0;
        bus.perdeu     = 1'b0;
        bus.db_timeout = 1'b0;
        case (estado)
            INICIAL:  if (bus.iniciar) proximo = PREPARA;
            PREPARA:  proximo = MOSTRA;
            MOSTRA: begin
                bus.leds = ram_rdata;
                if (timer == TW'(MOSTRA_CICLOS - 1)) proximo = ESPERA;
            end
            ESPERA: begin
                bus.leds = bus.botoes;
                if (pressionou)   proximo = REGISTRA;
                else if (expirou) proximo = FIM_TIMEOUT;
            end
            REGISTRA: proximo = COMPARA;
            COMPARA: begin
                if (!acerto)                               proximo = FIM_PERDEU;
                else if (contagem != rodada)               proximo = ESPERA;
                else if (rodada == AW'(MAX_RODADAS - 1))   proximo = FIM_GANHOU;
                else if (modo_r)                           proximo = ESPERA_NOVA;
                else                                       proximo = PROXIMA_RODADA;
            end
            ESPERA_NOVA: begin
                bus.leds = bus.botoes;
                if (pressionou && $onehot(bus.botoes)) proximo = GRAVA_NOVA;
                else if (expirou)                      proximo = FIM_TIMEOUT;
            end
            GRAVA_NOVA:     proximo = PROXIMA_RODADA;
            PROXIMA_RODADA: proximo = ESPERA;
            FIM_GANHOU: begin
                bus.pronto = 1'b1;
                bus.ganhou = 1'b1;
                if (bus.iniciar) proximo = PREPARA;
            end
            FIM_PERDEU: begin
                bus.pronto = 1'b1;
                bus.perdeu = 1'b1;
                if (bus.iniciar) proximo = PREPARA;
            end
            FIM_TIMEOUT: begin
                bus.pronto     = 1'b1;
                bus.perdeu     = 1'b1;
                bus.db_timeout = 1'b1;
                if (bus.iniciar) proximo = PREPARA;
            end
            default: proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rodada     <= '0;
            contagem   <= '0;
            timer      <= '0;
            jogada     <= '0;
            botoes_ant <= '0;
            modo_r     <= 1'b0;
        end else begin
            botoes_ant <= bus.botoes;
            timer      <= (conta && proximo == estado) ? timer + TW'(1) : '0;
            case (estado)
                PREPARA: begin
                    rodada   <= '0;
                    contagem <= '0;
                    jogada   <= '0;
                    modo_r   <= bus.modo;
                end
                REGISTRA:   jogada <= bus.botoes;
                COMPARA:    if (acerto && contagem != rodada) contagem <= contagem + UM;
                GRAVA_NOVA: jogada <= bus.botoes;
                PROXIMA_RODADA: begin
                    rodada   <= rodada_prox;
                    contagem <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.db_estado   = estado;
    assign bus.db_rodada   = rodada;
    assign bus.db_contagem = contagem;
    assign bus.db_jogada   = jogada;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// tb/tb_jogo_memoria_param.sv - scoreboard bench: expected state transitions queued, monitor compares each
module tb_jogo_memoria_param;
    import jogo_memoria_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jogo_memoria_if #(.BOTOES(4), .MAX_RODADAS(4)) bus ();

    jogo_memoria_param #(
        .BOTOES(4), .MAX_RODADAS(4), .TIMEOUT_CICLOS(50), .MOSTRA_CICLOS(20)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0] st;
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] j;
        logic [3:0] fl;
        bit         fchk;
        logic [3:0] ld;
        bit         lchk;
        int         plen;
    } ev_t;

    ev_t        q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [1:0] m_r = '0;
    logic [1:0] m_c = '0;
    logic [3:0] m_j = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic ev(input estado_t st, input int plen = 0, input logic [3:0] ld = 4'b0000);
        ev_t e;
        e.st   = st;
        e.r    = m_r;
        e.c    = m_c;
        e.j    = m_j;
        e.plen = plen;
        e.fchk = (st != PREPARA);
        case (st)
            FIM_GANHOU:  e.fl = 4'b1100;
            FIM_PERDEU:  e.fl = 4'b1010;
            FIM_TIMEOUT: e.fl = 4'b1011;
            default:     e.fl = 4'b0000;
        endcase
        e.lchk = st inside {INICIAL, MOSTRA, ESPERA, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT};
        e.ld   = (st == MOSTRA) ? 4'b0001 : (st == ESPERA) ? ld : 4'b0000;
        q.push_back(e);
    endtask

    task automatic wait_st(input estado_t s);
        int n = 0;
        while (bus.db_estado != s && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (bus.db_estado != s) begin
            checks++;
            errors++;
            $display("FAIL wait_state: got %0d want %0d", bus.db_estado, s);
        end
    endtask

    task automatic start(input logic md);
        @(negedge clk);
        ev(PREPARA);
        m_r = '0; m_c = '0; m_j = '0;
        ev(MOSTRA, 1);
        ev(ESPERA, 20);
        bus.modo    = md;
        bus.iniciar = 1'b1;
        repeat (10) @(negedge clk);
        bus.iniciar = 1'b0;
    endtask

    task automatic aperta(input estado_t onde, input logic [3:0] v, input int hold);
        wait_st(onde);
        @(negedge clk);
        bus.botoes = v;
        repeat (hold) @(negedge clk);
        bus.botoes = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic jogada(input logic [3:0] v, input estado_t nxt, input int hold = 2,
                          input logic [3:0] ld = 4'b0000);
        ev(REGISTRA);
        m_j = v;
        ev(COMPARA, 1);
        case (nxt)
            ESPERA: begin
                m_c++;
                ev(ESPERA, 1, ld);
            end
            PROXIMA_RODADA: begin
                ev(PROXIMA_RODADA, 1);
                m_r++;
                m_c = '0;
                ev(ESPERA, 1, ld);
            end
            default: ev(nxt, 1);
        endcase
        aperta(ESPERA, v, hold);
    endtask

    task automatic nova(input logic [3:0] v);
        ev(GRAVA_NOVA);
        m_j = v;
        ev(PROXIMA_RODADA, 1);
        m_r++;
        m_c = '0;
        ev(ESPERA, 1);
        aperta(ESPERA_NOVA, v, 2);
    endtask

    initial begin : monitor
        logic [4:0] prev_st = 5'd0;
        int         cnt = 1;
        int         nev = 0;
        ev_t        e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.db_estado != prev_st) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_state: got %0d want none", bus.db_estado);
                    end else begin
                        e = q.pop_front();
                        nev++;
                        chk($sformatf("ev%0d_estado", nev), 32'(bus.db_estado), 32'(e.st));
                        chk($sformatf("ev%0d_rodada", nev), 32'(bus.db_rodada), 32'(e.r));
                        chk($sformatf("ev%0d_contagem", nev), 32'(bus.db_contagem), 32'(e.c));
                        chk($sformatf("ev%0d_jogada", nev), 32'(bus.db_jogada), 32'(e.j));
                        if (e.fchk)
                            chk($sformatf("ev%0d_flags", nev),
                                32'({bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout}), 32'(e.fl));
                        if (e.lchk)
                            chk($sformatf("ev%0d_leds", nev), 32'(bus.leds), 32'(e.ld));
                        if (e.plen != 0)
                            chk($sformatf("ev%0d_prev_len", nev), 32'(cnt), 32'(e.plen));
                    end
                    prev_st = bus.db_estado;
                    cnt = 1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        bus.iniciar = 1'b0;
        bus.modo    = 1'b0;
        bus.botoes  = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rst_estado", 32'(bus.db_estado), 32'(INICIAL));
        chk("rst_outs", 32'({bus.leds, bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout,
                             bus.db_rodada, bus.db_contagem, bus.db_jogada}), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // append mode: first round records 0100, second round misses it
        start(1'b1);
        jogada(4'b0001, ESPERA_NOVA);
        nova(4'b0100);
        jogada(4'b0001, ESPERA);
        jogada(4'b0010, FIM_PERDEU);

        // append 1000 into entry 1, then async reset in the middle of ESPERA
        start(1'b1);
        jogada(4'b0001, ESPERA_NOVA);
        nova(4'b1000);
        wait_st(ESPERA);
        @(negedge clk);
        m_r = '0; m_c = '0; m_j = '0;
        ev(INICIAL);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_estado", 32'(bus.db_estado), 32'(INICIAL));
        chk("mid_rst_outs", 32'({bus.leds, bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout,
                                 bus.db_rodada, bus.db_contagem, bus.db_jogada}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // fixed mode win over the restored 0001,0010,0100,1000 sequence
        start(1'b0);
        jogada(4'b0001, PROXIMA_RODADA);
        jogada(4'b0001, ESPERA);
        jogada(4'b0010, PROXIMA_RODADA);
        jogada(4'b0001, ESPERA);
        jogada(4'b0010, ESPERA);
        jogada(4'b0100, PROXIMA_RODADA);
        jogada(4'b0001, ESPERA);
        jogada(4'b0010, ESPERA);
        jogada(4'b0100, ESPERA);
        jogada(4'b1000, FIM_GANHOU);

        // timeout, then restart clears the flags
        start(1'b0);
        ev(FIM_TIMEOUT, 50);
        wait_st(FIM_TIMEOUT);
        repeat (2) @(negedge clk);
        start(1'b0);

        // held button counts once; multi-hot press in ESPERA loses
        jogada(4'b0001, PROXIMA_RODADA, 6, 4'b0001);
        jogada(4'b0001, ESPERA);
        jogada(4'b0011, FIM_PERDEU);

        // multi-hot press in ESPERA_NOVA is ignored
        start(1'b1);
        jogada(4'b0001, ESPERA_NOVA);
        aperta(ESPERA_NOVA, 4'b0011, 3);
        nova(4'b1000);
        jogada(4'b0001, ESPERA);
        jogada(4'b1000, ESPERA_NOVA);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jogo_memoria_param.md
Name: jogo_memoria_param

Overview:
- Parametrised memory-game core ("Genius" style), successor to the fixed 4-button circuito_exp6 datapath plus FSM.
- Holds a move sequence in internal RAM and shows the first move on the leds.
- Each round the player repeats the sequence on the buttons. In append mode the player also records a new move at the end of every round.
- Reports ganhou, perdeu and timeout; sits directly under the board top level (debounced button inputs, LED and 7-seg debug outputs).

Parameters:
BOTOES, 4, number of buttons/leds; moves are one-hot of this width
MAX_RODADAS, 16, sequence length and rounds needed to win (power of 2, >=2)
TIMEOUT_CICLOS, 5000, idle cycles allowed while waiting for a press
MOSTRA_CICLOS, 2000, cycles the first move is displayed

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
iniciar  in  1  start/restart request, level sampled
modo  in  1  0 = fixed sequence, 1 = append (player adds a move each round); sampled in PREPARA
botoes  in  BOTOES  button levels
leds  out  BOTOES  move display / button echo
pronto  out  1  game over
ganhou  out  1  won
perdeu  out  1  lost (wrong move or timeout)
db_timeout  out  1  loss was caused by timeout
db_estado  out  5  FSM state code
db_rodada  out  clog2(MAX_RODADAS)  current round index
db_contagem  out  clog2(MAX_RODADAS)  current move index in the round
db_jogada  out  BOTOES  last registered press

Behaviour:
- Reset (async): FSM to INICIAL; all counters 0; all outputs 0.
  - RAM entry k is loaded with 1<<(k mod BOTOES), so entry0=0001 and entry1=0010.
- INICIAL: waits for iniciar=1, then goes to PREPARA.
- PREPARA (1 cycle): clears rodada, contagem, timer and db_jogada; latches modo; clears ganhou, perdeu and db_timeout. Goes to MOSTRA.
- MOSTRA: leds=RAM[0] for exactly MOSTRA_CICLOS cycles, then leds=0 and go to ESPERA.
- ESPERA: leds=botoes.
  - A press is detected on the transition from botoes==0 to botoes!=0 and triggers REGISTRA.
  - The timer increments every cycle. If it reaches TIMEOUT_CICLOS-1 with no press, go to FIM_TIMEOUT.
- REGISTRA (1 cycle): db_jogada<=botoes; timer cleared. Goes to COMPARA.
- COMPARA (1 cycle): correct iff db_jogada==RAM[contagem]. A multi-hot press is always wrong.
  - Wrong -> FIM_PERDEU.
  - Correct and contagem<rodada -> contagem+1, back to ESPERA (next press only after release).
  - Correct and contagem==rodada==MAX_RODADAS-1 -> FIM_GANHOU.
  - Correct and contagem==rodada<MAX_RODADAS-1:
    - modo=0 -> PROXIMA_RODADA.
    - modo=1 -> ESPERA_NOVA.
- ESPERA_NOVA: same edge detection and timeout as ESPERA.
  - On a one-hot press, go to GRAVA_NOVA; a multi-hot press is ignored.
- GRAVA_NOVA (1 cycle): RAM[rodada+1]<=botoes; db_jogada<=botoes. Goes to PROXIMA_RODADA.
- PROXIMA_RODADA (1 cycle): rodada+1, contagem<=0, timer<=0. Goes to ESPERA.
- FIM_GANHOU: ganhou=1, pronto=1.
- FIM_PERDEU: perdeu=1, pronto=1.
- FIM_TIMEOUT: perdeu=1, db_timeout=1, pronto=1.
- All FIM_* states hold their outputs until iniciar=1, then go to PREPARA. RAM contents persist across restarts; only reset restores them.
- A button still held when entering ESPERA or ESPERA_NOVA does not count until it is released.
- iniciar outside INICIAL and the FIM_* states is ignored.
- Reset mid-game aborts immediately to INICIAL with reset values.
- Counters never wrap: rodada is capped at MAX_RODADAS-1 by the FSM.
- db_estado codes: INICIAL=0, PREPARA=1, MOSTRA=2, ESPERA=3, REGISTRA=4, COMPARA=5, ESPERA_NOVA=6, GRAVA_NOVA=7, PROXIMA_RODADA=8, FIM_GANHOU=10, FIM_PERDEU=14, FIM_TIMEOUT=15.
  - Any illegal code goes to INICIAL.

Decomposition:
- Package jogo_memoria_pkg: state encodings above, and a function giving the reset pattern for entry k.
- Natural sub-module: jogo_memoria_ram, a MAX_RODADAS x BOTOES register file with async reset init, combinational read and sync write.
- FSM, timer, counters and edge detector stay in the top module.

Test Plan (BOTOES=4, MAX_RODADAS=4, TIMEOUT_CICLOS=50, MOSTRA_CICLOS=20):
1. Reset, iniciar for 10 cycles, modo=1 -> leds=0001 for 20 cycles, then state ESPERA.
2. Append loss: press 0001 (db_jogada=0001), then press new move 0100 (RAM[1]=0100, db_rodada=1). Round 2: press 0001 then 0010 -> perdeu=1, pronto=1, ganhou=0, db_timeout=0, db_estado=14.
3. modo=0 win: press the sequences 0001 / 0001,0010 / 0001,0010,0100 / 0001,0010,0100,1000 -> ganhou=1, pronto=1, db_rodada=3.
4. Timeout: after MOSTRA, no press for 50 cycles -> perdeu=1, db_timeout=1, db_estado=15. Then iniciar -> outputs clear, leds=0001 again.
5. Held and multi-hot buttons:
   - Button held across REGISTRA counts once.
   - A 0011 press in ESPERA -> perdeu.
   - A 0011 press in ESPERA_NOVA is ignored; the FSM stays in ESPERA_NOVA.
6. Async reset asserted mid-ESPERA on a non-edge -> outputs 0 and INICIAL immediately. RAM restored: entry1=0010 after an earlier append.
